// File: rtl/xgmii_pkg.sv
// Shared definitions for the XGMII TX frame arbiter.
//   - FSM state encodings (2-bit, plain localparams)
//   - MII64 mod codes and the abort word used to poison a truncated frame
//   - tx_word_t: one registered word towards the TX encoder
//   - needs_ifg(): whether an EOF word forces one extra idle cycle in the encoder
package xgmii_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SEND  = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;

   localparam logic [2:0]  MOD_FULL   = 3'h0;
   localparam logic [2:0]  MOD_UNDRUN = 3'h1;
   localparam logic [63:0] TXD_ABORT  = 64'h0;

   typedef struct packed {
      logic        dv;
      logic        sof;
      logic        eof;
      logic [2:0]  mod;
      logic [63:0] d;
   } tx_word_t;

   // EOF words with 0 (=8), 5, 6 or 7 valid bytes leave no room for the
   // terminate character in the same XGMII column group, so the encoder
   // needs one extra idle word before the next start.
   function automatic logic needs_ifg(input logic [2:0] mod);
      return (mod == MOD_FULL) || (mod >= 3'd5);
   endfunction

endpackage

// File: rtl/rr_arb.sv
// N-way round-robin picker.
//   clk, rst   : clock, asynchronous active-high reset
//   req        : per-source request vector
//   adv        : advance pointer past adv_id (frame completed)
//   adv_id     : source that just completed a frame
//   gnt_valid  : at least one request present
//   gnt_id     : first requester at or after the pointer, circular
// The pick is combinational; only the pointer is registered.
module rr_arb #(
   parameter int N_SRC = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] req,
   input  logic             adv,
   input  logic [1:0]       adv_id,
   output logic             gnt_valid,
   output logic [1:0]       gnt_id
);

   logic [1:0]         ptr_q, ptr_d;
   logic [2:0]         nxt;
   logic [2:0]         sum;
   logic [2*N_SRC-1:0] req_rot;

   always_comb begin
      nxt = {1'b0, adv_id} + 3'd1;
      if (nxt >= 3'(N_SRC)) nxt = 3'd0;
      ptr_d = adv ? nxt[1:0] : ptr_q;
   end

   // Rotate the request vector so that bit 0 is the pointer position; the
   // lowest set bit of the rotated vector is the winner.
   always_comb begin
      req_rot   = {req, req} >> ptr_q;
      gnt_valid = 1'b0;
      gnt_id    = ptr_q;
      sum       = 3'd0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            sum = {1'b0, ptr_q} + 3'(k);
            if (sum >= 3'(N_SRC)) sum = sum - 3'(N_SRC);
            gnt_valid = 1'b1;
            gnt_id    = sum[1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= 2'd0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/xgmii_tx_arb.sv
// Round-robin whole-frame arbiter in front of the mii64 -> XGMII TX encoder.
//   Clk, Reset          : TX clock, asynchronous active-high reset
//   src_dv/d/sof/eof/mod: per-source mii64 word streams (src i at slice i)
//   src_rdy             : word accepted when src_dv[i] & src_rdy[i]
//   Txdv/Txd/TxSof/TxEof/TxMod : registered mii64 stream to the encoder
//   grant_id            : source currently or last granted
//   drop_runt           : 1-cycle pulse, single-word frame discarded
//   err_undrun          : 1-cycle pulse, frame cut short (underrun or MAX_WORDS)
//
// state | meaning
// IDLE  | waiting for a SOF request; non-SOF words are drained for resync
// SEND  | forwarding words of the granted source
// FLUSH | frame already terminated; discard source words up to its EOF
// GAP   | forced idle after EOF, down-counter to zero
module xgmii_tx_arb
   import xgmii_pkg::*;
#(
   parameter int N_SRC     = 2,
   parameter int MIN_GAP   = 0,
   parameter int MAX_WORDS = 1200
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [N_SRC-1:0]    src_dv,
   input  logic [64*N_SRC-1:0] src_d,
   input  logic [N_SRC-1:0]    src_sof,
   input  logic [N_SRC-1:0]    src_eof,
   input  logic [3*N_SRC-1:0]  src_mod,
   output logic [N_SRC-1:0]    src_rdy,
   output logic                Txdv,
   output logic [63:0]         Txd,
   output logic                TxSof,
   output logic                TxEof,
   output logic [2:0]          TxMod,
   output logic [1:0]          grant_id,
   output logic                drop_runt,
   output logic                err_undrun
);

   localparam logic [10:0] WCNT_LAST = 11'(MAX_WORDS - 1);

   logic [1:0]  state_q, state_d;
   logic [1:0]  grant_q, grant_d;
   logic        first_q, first_d;
   logic [10:0] wcnt_q, wcnt_d;
   logic [3:0]  gap_cnt_q, gap_cnt_d;
   tx_word_t    tx_q, tx_d;
   logic        drop_runt_q, drop_runt_d;
   logic        err_undrun_q, err_undrun_d;

   logic [N_SRC-1:0] rdy;
   logic [N_SRC-1:0] grant_oh;
   logic             sel_dv, sel_sof, sel_eof;
   logic [2:0]       sel_mod;
   logic [63:0]      sel_d;
   logic             rr_adv;
   logic             gnt_valid;
   logic [1:0]       gnt_id;
   logic [4:0]       len_send, len_flush;

   function automatic logic [4:0] gap_len(input logic [2:0] mod);
      return 5'(MIN_GAP) + {4'd0, needs_ifg(mod)};
   endfunction

   rr_arb #(.N_SRC(N_SRC)) u_rr_arb (
      .clk       (Clk),
      .rst       (Reset),
      .req       (src_dv & src_sof),
      .adv       (rr_adv),
      .adv_id    (grant_q),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   always_comb begin
      grant_oh = '0;
      sel_dv   = 1'b0;
      sel_sof  = 1'b0;
      sel_eof  = 1'b0;
      sel_mod  = MOD_FULL;
      sel_d    = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant_q == 2'(i)) begin
            grant_oh[i] = 1'b1;
            sel_dv      = src_dv[i];
            sel_sof     = src_sof[i];
            sel_eof     = src_eof[i];
            sel_mod     = src_mod[3*i +: 3];
            sel_d       = src_d[64*i +: 64];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      first_d      = first_q;
      wcnt_d       = wcnt_q;
      gap_cnt_d    = gap_cnt_q;
      tx_d         = tx_q;
      tx_d.dv      = 1'b0;
      tx_d.sof     = 1'b0;
      tx_d.eof     = 1'b0;
      drop_runt_d  = 1'b0;
      err_undrun_d = 1'b0;
      rr_adv       = 1'b0;
      rdy          = '0;
      len_send     = gap_len(sel_mod);
      len_flush    = gap_len(MOD_FULL);

      case (state_q)
         ST_IDLE: begin
            // Words arriving without SOF belong to no frame: drain them.
            rdy = src_dv & ~src_sof;
            if (gnt_valid) begin
               grant_d = gnt_id;
               first_d = 1'b1;
               wcnt_d  = '0;
               state_d = ST_SEND;
            end
         end

         ST_SEND: begin
            rdy = grant_oh;
            if (sel_dv) begin
               if (first_q && sel_sof && sel_eof) begin
                  drop_runt_d = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  first_d  = 1'b0;
                  wcnt_d   = (wcnt_q == '1) ? wcnt_q : wcnt_q + 11'd1;
                  tx_d.dv  = 1'b1;
                  tx_d.sof = first_q;
                  tx_d.d   = sel_d;
                  tx_d.eof = sel_eof;
                  tx_d.mod = sel_eof ? sel_mod : MOD_FULL;
                  if (sel_eof) begin
                     rr_adv = 1'b1;
                     if (len_send == 5'd0) begin
                        state_d = ST_IDLE;
                     end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = 4'(len_send - 5'd1);
                     end
                  end else if (wcnt_q >= WCNT_LAST) begin
                     // Jumbo guard: this word becomes the poisoned EOF so the
                     // frame never exceeds MAX_WORDS on the wire.
                     tx_d.eof     = 1'b1;
                     tx_d.mod     = MOD_UNDRUN;
                     tx_d.d       = TXD_ABORT;
                     err_undrun_d = 1'b1;
                     state_d      = ST_FLUSH;
                  end
               end
            end else if (!first_q) begin
               // The encoder cannot stall mid-frame: close it with a word
               // that is guaranteed to break the FCS.
               tx_d.dv      = 1'b1;
               tx_d.eof     = 1'b1;
               tx_d.mod     = MOD_UNDRUN;
               tx_d.d       = TXD_ABORT;
               err_undrun_d = 1'b1;
               state_d      = ST_FLUSH;
            end else begin
               // Requester withdrew its SOF before it was taken.
               state_d = ST_IDLE;
            end
         end

         ST_FLUSH: begin
            rdy = grant_oh;
            if (sel_dv && sel_eof) begin
               rr_adv = 1'b1;
               if (len_flush == 5'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d   = ST_GAP;
                  gap_cnt_d = 4'(len_flush - 5'd1);
               end
            end
         end

         default: begin
            if (gap_cnt_q == 4'd0) state_d = ST_IDLE;
            else                   gap_cnt_d = gap_cnt_q - 4'd1;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         grant_q      <= 2'd0;
         first_q      <= 1'b0;
         wcnt_q       <= '0;
         gap_cnt_q    <= '0;
         tx_q         <= '0;
         drop_runt_q  <= 1'b0;
         err_undrun_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         first_q      <= first_d;
         wcnt_q       <= wcnt_d;
         gap_cnt_q    <= gap_cnt_d;
         tx_q         <= tx_d;
         drop_runt_q  <= drop_runt_d;
         err_undrun_q <= err_undrun_d;
      end
   end

   // Ready is combinational; hold it low while reset is asserted so no
   // source sees a handshake during reset.
   assign src_rdy    = Reset ? '0 : rdy;
   assign Txdv       = tx_q.dv;
   assign Txd        = tx_q.d;
   assign TxSof      = tx_q.sof;
   assign TxEof      = tx_q.eof;
   assign TxMod      = tx_q.mod;
   assign grant_id   = grant_q;
   assign drop_runt  = drop_runt_q;
   assign err_undrun = err_undrun_q;

endmodule

// File: tb/tb_xgmii_tx_arb.sv
module tb_xgmii_tx_arb;

   logic         Clk = 1'b0;
   logic         Reset = 1'b0;
   logic [1:0]   src_dv, src_sof, src_eof, src_rdy;
   logic [127:0] src_d;
   logic [5:0]   src_mod;
   logic         Txdv, TxSof, TxEof, drop_runt, err_undrun;
   logic [63:0]  Txd;
   logic [2:0]   TxMod;
   logic [1:0]   grant_id;

   typedef struct {
      logic        hole;
      logic [63:0] d;
      logic        sof;
      logic        eof;
      logic [2:0]  mod;
   } sw_t;

   typedef struct {
      int          cyc;
      logic [63:0] d;
      logic        sof;
      logic        eof;
      logic [2:0]  mod;
      logic [1:0]  gid;
   } ow_t;

   sw_t q0[$];
   sw_t q1[$];
   ow_t olog[$];
   int  cyc, runt_cnt, runt_cyc, err_cnt, err_cyc;
   int  n_tests = 0;
   int  n_fail  = 0;

   xgmii_tx_arb #(.N_SRC(2), .MIN_GAP(0), .MAX_WORDS(8)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .src_dv     (src_dv),
      .src_d      (src_d),
      .src_sof    (src_sof),
      .src_eof    (src_eof),
      .src_mod    (src_mod),
      .src_rdy    (src_rdy),
      .Txdv       (Txdv),
      .Txd        (Txd),
      .TxSof      (TxSof),
      .TxEof      (TxEof),
      .TxMod      (TxMod),
      .grant_id   (grant_id),
      .drop_runt  (drop_runt),
      .err_undrun (err_undrun)
   );

   always #5 Clk = ~Clk;

   task automatic drive_srcs();
      src_dv = '0; src_sof = '0; src_eof = '0; src_d = '0; src_mod = '0;
      if (q0.size() > 0 && !q0[0].hole) begin
         src_dv[0] = 1'b1; src_sof[0] = q0[0].sof; src_eof[0] = q0[0].eof;
         src_mod[2:0] = q0[0].mod; src_d[63:0] = q0[0].d;
      end
      if (q1.size() > 0 && !q1[0].hole) begin
         src_dv[1] = 1'b1; src_sof[1] = q1[0].sof; src_eof[1] = q1[0].eof;
         src_mod[5:3] = q1[0].mod; src_d[127:64] = q1[0].d;
      end
   endtask

   task automatic push_frame(input int src, input logic [63:0] base, input int n,
                             input logic [2:0] mod);
      sw_t w;
      for (int i = 0; i < n; i++) begin
         w.hole = 1'b0;
         w.d    = base + 64'(i);
         w.sof  = (i == 0);
         w.eof  = (i == n - 1);
         w.mod  = (i == n - 1) ? mod : 3'd0;
         if (src == 0) q0.push_back(w);
         else          q1.push_back(w);
      end
   endtask

   task automatic push_hole(input int src);
      sw_t w;
      w.hole = 1'b1; w.d = '0; w.sof = 1'b0; w.eof = 1'b0; w.mod = '0;
      if (src == 0) q0.push_back(w);
      else          q1.push_back(w);
   endtask

   // One clock: record handshakes before the edge, sample outputs 1 after it.
   task automatic step();
      logic [1:0] hs;
      logic       h0, h1;
      ow_t        ow;
      @(negedge Clk);
      hs = src_dv & src_rdy;
      h0 = (q0.size() > 0) && q0[0].hole;
      h1 = (q1.size() > 0) && q1[0].hole;
      @(posedge Clk);
      #1;
      cyc++;
      if ((hs[0] || h0) && q0.size() > 0) q0.delete(0);
      if ((hs[1] || h1) && q1.size() > 0) q1.delete(0);
      drive_srcs();
      if (Txdv) begin
         ow.cyc = cyc; ow.d = Txd; ow.sof = TxSof; ow.eof = TxEof;
         ow.mod = TxMod; ow.gid = grant_id;
         olog.push_back(ow);
      end
      if (drop_runt)  begin runt_cnt++; runt_cyc = cyc; end
      if (err_undrun) begin err_cnt++;  err_cyc  = cyc; end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      q0.delete(); q1.delete(); olog.delete();
      runt_cnt = 0; runt_cyc = -1; err_cnt = 0; err_cyc = -1;
      drive_srcs();
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      cyc = 0;
   endtask

   task automatic test_reset();
      #2;
      src_dv = 2'b11; src_sof = 2'b00; src_eof = '0; src_d = '1; src_mod = '1;
      Reset = 1'b1;
      #1;
      n_tests++;
      if ({Txdv, TxSof, TxEof, TxMod, grant_id, drop_runt, err_undrun} !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 0", {Txdv, TxSof, TxEof, TxMod, grant_id, drop_runt, err_undrun});
      end
      n_tests++;
      if (Txd !== 64'd0) begin n_fail++; $display("FAIL reset_txd: got %h want 0", Txd); end
      n_tests++;
      if (src_rdy !== 2'b00) begin n_fail++; $display("FAIL reset_rdy: got %b want 00", src_rdy); end
      do_reset();
      // resync: dv without sof in IDLE is drained
      src_dv = 2'b01; src_sof = 2'b00;
      #1;
      n_tests++;
      if (src_rdy !== 2'b01) begin n_fail++; $display("FAIL resync_rdy: got %b want 01", src_rdy); end
      step();
      n_tests++;
      if (Txdv !== 1'b0) begin n_fail++; $display("FAIL resync_txdv: got %b want 0", Txdv); end
   endtask

   task automatic test_single();
      do_reset();
      push_frame(0, 64'hA0, 4, 3'd3);
      push_frame(0, 64'hA8, 2, 3'd4);
      drive_srcs();
      run(12);
      n_tests++;
      if (olog.size() !== 6) begin n_fail++; $display("FAIL single_count: got %0d want 6", olog.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (olog[i].d !== 64'hA0 + 64'(i) || olog[i].cyc !== 2 + i || olog[i].sof !== (i == 0)
                || olog[i].eof !== (i == 3)) begin
               n_fail++;
               $display("FAIL single_w%0d: got d=%h cyc=%0d sof=%b eof=%b want d=%h cyc=%0d", i,
                        olog[i].d, olog[i].cyc, olog[i].sof, olog[i].eof, 64'hA0 + 64'(i), 2 + i);
            end
         end
         n_tests++;
         if (olog[3].mod !== 3'd3) begin n_fail++; $display("FAIL single_mod: got %0d want 3", olog[3].mod); end
         n_tests++;
         if (olog[4].cyc !== 7 || olog[4].sof !== 1'b1 || olog[4].d !== 64'hA8) begin
            n_fail++;
            $display("FAIL single_next_sof: got cyc=%0d sof=%b d=%h want cyc=7 sof=1 d=a8",
                     olog[4].cyc, olog[4].sof, olog[4].d);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp_d [12];
      int          exp_sof_cyc [4];
      logic [1:0]  exp_gid [4];
      exp_sof_cyc = '{2, 7, 12, 17};
      exp_gid     = '{2'd0, 2'd1, 2'd0, 2'd1};
      for (int i = 0; i < 3; i++) begin
         exp_d[i]     = 64'hB0 + 64'(i);
         exp_d[3 + i] = 64'hC0 + 64'(i);
         exp_d[6 + i] = 64'hB3 + 64'(i);
         exp_d[9 + i] = 64'hC3 + 64'(i);
      end
      do_reset();
      push_frame(0, 64'hB0, 3, 3'd0);
      push_frame(0, 64'hB3, 3, 3'd0);
      push_frame(1, 64'hC0, 3, 3'd0);
      push_frame(1, 64'hC3, 3, 3'd0);
      drive_srcs();
      run(22);
      n_tests++;
      if (olog.size() !== 12) begin n_fail++; $display("FAIL b2b_count: got %0d want 12", olog.size()); end
      else begin
         for (int f = 0; f < 4; f++) begin
            n_tests++;
            if (olog[3*f].gid !== exp_gid[f] || olog[3*f].cyc !== exp_sof_cyc[f] || olog[3*f].sof !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b_frame%0d: got gid=%0d cyc=%0d sof=%b want gid=%0d cyc=%0d sof=1", f,
                        olog[3*f].gid, olog[3*f].cyc, olog[3*f].sof, exp_gid[f], exp_sof_cyc[f]);
            end
         end
         for (int i = 0; i < 12; i++) begin
            n_tests++;
            if (olog[i].d !== exp_d[i]) begin
               n_fail++; $display("FAIL b2b_d%0d: got %h want %h", i, olog[i].d, exp_d[i]);
            end
         end
      end
   endtask

   task automatic test_runt();
      do_reset();
      push_frame(1, 64'hD1, 1, 3'd2);
      push_hole(0);
      push_hole(0);
      push_frame(0, 64'hE0, 2, 3'd4);
      drive_srcs();
      run(8);
      n_tests++;
      if (runt_cnt !== 1 || runt_cyc !== 2) begin
         n_fail++; $display("FAIL runt_pulse: got count=%0d cyc=%0d want count=1 cyc=2", runt_cnt, runt_cyc);
      end
      n_tests++;
      if (olog.size() !== 2) begin n_fail++; $display("FAIL runt_count: got %0d want 2", olog.size()); end
      else begin
         n_tests++;
         if (olog[0].d !== 64'hE0 || olog[0].cyc !== 4 || olog[0].gid !== 2'd0 || olog[0].sof !== 1'b1) begin
            n_fail++;
            $display("FAIL runt_next: got d=%h cyc=%0d gid=%0d want d=e0 cyc=4 gid=0",
                     olog[0].d, olog[0].cyc, olog[0].gid);
         end
         n_tests++;
         if (olog[1].eof !== 1'b1 || olog[1].mod !== 3'd4) begin
            n_fail++; $display("FAIL runt_next_eof: got eof=%b mod=%0d want eof=1 mod=4", olog[1].eof, olog[1].mod);
         end
      end
   endtask

   task automatic test_underrun();
      do_reset();
      push_frame(0, 64'hF0, 2, 3'd0);
      q0[1].eof = 1'b0;
      push_hole(0);
      push_frame(0, 64'hF2, 4, 3'd0);
      q0[3].sof = 1'b0;
      drive_srcs();
      run(12);
      n_tests++;
      if (olog.size() !== 3) begin n_fail++; $display("FAIL undrun_count: got %0d want 3", olog.size()); end
      else begin
         n_tests++;
         if (olog[1].d !== 64'hF1 || olog[1].eof !== 1'b0) begin
            n_fail++; $display("FAIL undrun_w1: got d=%h eof=%b want d=f1 eof=0", olog[1].d, olog[1].eof);
         end
         n_tests++;
         if (olog[2].d !== 64'd0 || olog[2].eof !== 1'b1 || olog[2].mod !== 3'd1 || olog[2].cyc !== 4
             || olog[2].sof !== 1'b0) begin
            n_fail++;
            $display("FAIL undrun_term: got d=%h eof=%b mod=%0d cyc=%0d want d=0 eof=1 mod=1 cyc=4",
                     olog[2].d, olog[2].eof, olog[2].mod, olog[2].cyc);
         end
      end
      n_tests++;
      if (err_cnt !== 1 || err_cyc !== 4) begin
         n_fail++; $display("FAIL undrun_pulse: got count=%0d cyc=%0d want count=1 cyc=4", err_cnt, err_cyc);
      end
      n_tests++;
      if (q0.size() !== 0) begin n_fail++; $display("FAIL undrun_flush: got %0d words left want 0", q0.size()); end
      n_tests++;
      if (Txdv !== 1'b0 || Txd !== 64'd0 || TxMod !== 3'd1) begin
         n_fail++; $display("FAIL undrun_hold: got dv=%b d=%h mod=%0d want dv=0 d=0 mod=1", Txdv, Txd, TxMod);
      end
   endtask

   task automatic test_max_words();
      do_reset();
      push_frame(0, 64'h60, 10, 3'd5);
      drive_srcs();
      run(14);
      n_tests++;
      if (olog.size() !== 8) begin n_fail++; $display("FAIL maxw_count: got %0d want 8", olog.size()); end
      else begin
         n_tests++;
         if (olog[6].d !== 64'h66 || olog[6].eof !== 1'b0) begin
            n_fail++; $display("FAIL maxw_w6: got d=%h eof=%b want d=66 eof=0", olog[6].d, olog[6].eof);
         end
         n_tests++;
         if (olog[7].d !== 64'd0 || olog[7].eof !== 1'b1 || olog[7].mod !== 3'd1 || olog[7].cyc !== 9) begin
            n_fail++;
            $display("FAIL maxw_term: got d=%h eof=%b mod=%0d cyc=%0d want d=0 eof=1 mod=1 cyc=9",
                     olog[7].d, olog[7].eof, olog[7].mod, olog[7].cyc);
         end
      end
      n_tests++;
      if (err_cnt !== 1 || err_cyc !== 9) begin
         n_fail++; $display("FAIL maxw_pulse: got count=%0d cyc=%0d want count=1 cyc=9", err_cnt, err_cyc);
      end
      n_tests++;
      if (q0.size() !== 0) begin n_fail++; $display("FAIL maxw_flush: got %0d words left want 0", q0.size()); end
   endtask

   task automatic test_reset_midframe();
      do_reset();
      push_frame(0, 64'h70, 2, 3'd4);
      push_frame(1, 64'h80, 5, 3'd0);
      drive_srcs();
      run(7);
      n_tests++;
      if (Txdv !== 1'b1 || Txd !== 64'h82 || grant_id !== 2'd1) begin
         n_fail++; $display("FAIL midrst_pre: got dv=%b d=%h gid=%0d want dv=1 d=82 gid=1", Txdv, Txd, grant_id);
      end
      #2;
      Reset = 1'b1;
      #1;
      n_tests++;
      if ({Txdv, TxSof, TxEof, TxMod, grant_id, drop_runt, err_undrun, src_rdy} !== 12'd0 || Txd !== 64'd0) begin
         n_fail++;
         $display("FAIL midrst_async: got ctrl=%b d=%h want all 0",
                  {Txdv, TxSof, TxEof, TxMod, grant_id, drop_runt, err_undrun, src_rdy}, Txd);
      end
      do_reset();
      push_frame(0, 64'h90, 2, 3'd2);
      push_frame(1, 64'h98, 2, 3'd2);
      drive_srcs();
      run(6);
      n_tests++;
      if (olog.size() < 1) begin n_fail++; $display("FAIL midrst_restart: got no output want 1+ words"); end
      else if (olog[0].gid !== 2'd0 || olog[0].d !== 64'h90 || olog[0].cyc !== 2) begin
         n_fail++;
         $display("FAIL midrst_restart: got gid=%0d d=%h cyc=%0d want gid=0 d=90 cyc=2",
                  olog[0].gid, olog[0].d, olog[0].cyc);
      end
   endtask

   initial begin
      src_dv = '0; src_sof = '0; src_eof = '0; src_d = '0; src_mod = '0;
      cyc = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_runt();
      test_underrun();
      test_max_words();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
